// File: rtl/trap_ctrl.sv
// Machine-mode trap responder: owns the M-mode trap CSRs, takes timer interrupts,
// ecall and mret at commit, and issues a one-cycle flush/redirect strobe.
module trap_ctrl #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tint,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [XLEN-1:0] commit_next_pc,
  input  logic            ecall,
  input  logic            mret,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            MIE,
  output logic            MTIE,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;

  localparam logic [XLEN-1:0] ALIGN       = ~(XLEN'(3));
  localparam logic [XLEN-1:0] CAUSE_INT   = {1'b1, (XLEN-1)'(7)};
  localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t          state;
  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic            mie_mtie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;

  logic active;
  logic wr;
  logic take_int;
  logic take_ecall;
  logic take_mret;
  logic mie_w;
  logic mpie_w;

  assign MIE  = mstatus_mie;
  assign MTIE = mie_mtie;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      A_MSTATUS: begin
        csr_rdata[3]     = mstatus_mie;
        csr_rdata[7]     = mstatus_mpie;
        csr_rdata[12:11] = 2'b11;
      end
      A_MIE:    csr_rdata[7] = mie_mtie;
      A_MTVEC:  csr_rdata = mtvec;
      A_MEPC:   csr_rdata = mepc;
      A_MCAUSE: csr_rdata = mcause;
      A_MIP:    csr_rdata[7] = tint;
      default:  csr_rdata = '0;
    endcase
  end

  // Interrupt decision sees pre-write MIE/MTIE; trap field updates see post-write mstatus.
  always_comb begin
    active     = commit_valid && (state == IDLE);
    wr         = active && csr_we;
    take_int   = active && tint && mstatus_mie && mie_mtie;
    take_ecall = active && ecall && !take_int;
    take_mret  = active && mret && !take_int && !ecall;
    mie_w      = (wr && csr_addr == A_MSTATUS) ? csr_wdata[3] : mstatus_mie;
    mpie_w     = (wr && csr_addr == A_MSTATUS) ? csr_wdata[7] : mstatus_mpie;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      mstatus_mie    <= 1'b0;
      mstatus_mpie   <= 1'b0;
      mie_mtie       <= 1'b0;
      mtvec          <= MTVEC_RST & ALIGN;
      mepc           <= '0;
      mcause         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      if (wr) begin
        case (csr_addr)
          A_MSTATUS: begin
            mstatus_mie  <= csr_wdata[3];
            mstatus_mpie <= csr_wdata[7];
          end
          A_MIE:    mie_mtie <= csr_wdata[7];
          A_MTVEC:  mtvec    <= csr_wdata & ALIGN;
          A_MEPC:   mepc     <= csr_wdata & ALIGN;
          A_MCAUSE: mcause   <= csr_wdata;
          default:  ;
        endcase
      end
      // Later assignments deliberately override the CSR write on shared fields.
      if (take_int || take_ecall) begin
        mepc           <= (take_int ? commit_next_pc : commit_pc) & ALIGN;
        mcause         <= take_int ? CAUSE_INT : CAUSE_ECALL;
        mstatus_mpie   <= mie_w;
        mstatus_mie    <= 1'b0;
        redirect_pc    <= mtvec;
        redirect_valid <= 1'b1;
        state          <= REDIRECT;
      end else if (take_mret) begin
        mstatus_mie    <= mpie_w;
        mstatus_mpie   <= 1'b1;
        redirect_pc    <= mepc;
        redirect_valid <= 1'b1;
        state          <= REDIRECT;
      end
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tint;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [63:0] commit_next_pc;
  logic        ecall;
  logic        mret;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata;
  logic        mie_pin;
  logic        mtie_pin;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  int n_vec  = 0;
  int n_fail = 0;

  trap_ctrl #(.XLEN(64), .MTVEC_RST(64'h1003)) dut (
    .clk(clk), .rst(rst), .tint(tint), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_next_pc(commit_next_pc),
    .ecall(ecall), .mret(mret), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .MIE(mie_pin), .MTIE(mtie_pin),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, cv, tint, ec, mr, we;
    logic [11:0] addr;
    logic [63:0] wdata, pc, npc;
    logic        exp_rv;
    logic [63:0] exp_rpc;
    logic        exp_mie, exp_mtie;
    logic [11:0] rd_addr;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, cv, ti, ec, mr, we, input logic [11:0] a,
                              input logic [63:0] wd, pc, npc, input logic erv,
                              input logic [63:0] erpc, input logic emie, emtie,
                              input logic [11:0] ra, input logic [63:0] erd);
    vec_t v;
    v.rst = r; v.cv = cv; v.tint = ti; v.ec = ec; v.mr = mr; v.we = we;
    v.addr = a; v.wdata = wd; v.pc = pc; v.npc = npc;
    v.exp_rv = erv; v.exp_rpc = erpc; v.exp_mie = emie; v.exp_mtie = emtie;
    v.rd_addr = ra; v.exp_rd = erd;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic r, cv, ti, ec, mr, we, input logic [11:0] a,
                                input logic [63:0] wd, pc, npc);
    rst = r; commit_valid = cv; tint = ti; ecall = ec; mret = mr; csr_we = we;
    csr_addr = a; csr_wdata = wd; commit_pc = pc; commit_next_pc = npc;
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    apply_stimulus(v.rst, v.cv, v.tint, v.ec, v.mr, v.we, v.addr, v.wdata, v.pc, v.npc);
    @(posedge clk);
    #1;
    csr_addr = v.rd_addr;
    #1;
    check_output({tag, " redirect_valid"}, 64'(redirect_valid), 64'(v.exp_rv));
    if (v.exp_rv) check_output({tag, " redirect_pc"}, redirect_pc, v.exp_rpc);
    check_output({tag, " MIE"}, 64'(mie_pin), 64'(v.exp_mie));
    check_output({tag, " MTIE"}, 64'(mtie_pin), 64'(v.exp_mtie));
    check_output({tag, " csr_rdata"}, csr_rdata, v.exp_rd);
  endtask

  // Behavioural reference model
  logic        m_mie, m_mpie, m_mtie, m_rv;
  logic [63:0] m_mtvec, m_mepc, m_mcause, m_rpc;

  function automatic logic [63:0] model_read(input logic [11:0] a, input logic ti);
    case (a)
      12'h300: return 64'h1800 + (m_mie ? 64'd8 : 64'd0) + (m_mpie ? 64'd128 : 64'd0);
      12'h304: return m_mtie ? 64'd128 : 64'd0;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return ti ? 64'd128 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_step();
    logic        busy, irq;
    logic [63:0] old_mtvec, old_mepc;
    busy = m_rv;
    m_rv = 1'b0;
    if (rst) begin
      m_mie = 0; m_mpie = 0; m_mtie = 0; m_mtvec = 64'h1000;
      m_mepc = 0; m_mcause = 0; m_rpc = 0;
    end else if (!busy && commit_valid) begin
      irq       = tint && m_mie && m_mtie;
      old_mtvec = m_mtvec;
      old_mepc  = m_mepc;
      if (csr_we) begin
        case (csr_addr)
          12'h300: begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
          12'h304: m_mtie = csr_wdata[7];
          12'h305: m_mtvec = csr_wdata - (csr_wdata % 4);
          12'h341: m_mepc = csr_wdata - (csr_wdata % 4);
          12'h342: m_mcause = csr_wdata;
          default: ;
        endcase
      end
      if (irq || ecall) begin
        m_mepc   = irq ? commit_next_pc - (commit_next_pc % 4) : commit_pc - (commit_pc % 4);
        m_mcause = irq ? 64'h8000_0000_0000_0007 : 64'd11;
        m_mpie   = m_mie;
        m_mie    = 0;
        m_rv     = 1;
        m_rpc    = old_mtvec;
      end else if (mret) begin
        m_mie  = m_mpie;
        m_mpie = 1;
        m_rv   = 1;
        m_rpc  = old_mepc;
      end
    end
  endtask

  localparam logic [11:0] ADDRS[8] = '{12'h300, 12'h304, 12'h305, 12'h341,
                                      12'h342, 12'h344, 12'h301, 12'h7C0};

  initial begin
    apply_stimulus(1, 0, 0, 0, 0, 0, 12'h0, 0, 0, 0);
    m_rv = 0;
    repeat (2) @(posedge clk);
    #1;

    //        rst cv ti ec mr we addr     wdata         pc            npc           rv rpc           mie mtie rd       exp_rd
    vecs.push_back(mk(1,0,0,0,0,0,12'h000,0,            0,            0,            0,0,            0,0, 12'h300,64'h1800));
    vecs.push_back(mk(0,0,0,0,0,0,12'h000,0,            0,            0,            0,0,            0,0, 12'h305,64'h1000));
    vecs.push_back(mk(0,0,0,0,0,0,12'h000,0,            0,            0,            0,0,            0,0, 12'h341,64'h0));
    vecs.push_back(mk(0,0,0,0,0,0,12'h000,0,            0,            0,            0,0,            0,0, 12'h342,64'h0));
    vecs.push_back(mk(0,0,0,0,0,0,12'h000,0,            0,            0,            0,0,            0,0, 12'h304,64'h0));
    vecs.push_back(mk(0,0,0,0,0,0,12'h000,0,            0,            0,            0,0,            0,0, 12'h344,64'h0));
    vecs.push_back(mk(0,1,0,0,0,1,12'h305,64'h80000103,0,            0,            0,0,            0,0, 12'h305,64'h80000100));
    vecs.push_back(mk(0,1,0,0,0,1,12'h304,64'hFFFF,    0,            0,            0,0,            0,1, 12'h304,64'h80));
    vecs.push_back(mk(0,1,0,0,0,1,12'h300,64'h8,       0,            0,            0,0,            1,1, 12'h300,64'h1808));
    vecs.push_back(mk(0,1,1,0,0,0,12'h000,0,    64'h80000010,64'h80000014,1,64'h80000100,0,1, 12'h341,64'h80000014));
    vecs.push_back(mk(0,0,1,0,0,0,12'h000,0,            0,            0,            0,0,            0,1, 12'h342,64'h8000000000000007));
    vecs.push_back(mk(0,1,1,0,0,0,12'h000,0,    64'h80000018,64'h8000001C,0,0,            0,1, 12'h300,64'h1880));
    vecs.push_back(mk(0,1,1,0,0,0,12'h000,0,    64'h8000001C,64'h80000020,0,0,            0,1, 12'h344,64'h80));
    vecs.push_back(mk(0,1,1,0,1,0,12'h000,0,    64'h80000020,64'h80000024,1,64'h80000014,1,1, 12'h300,64'h1888));
    vecs.push_back(mk(0,1,1,0,0,0,12'h000,0,    64'h80000024,64'h80000028,0,0,            1,1, 12'h341,64'h80000014));
    vecs.push_back(mk(0,1,1,0,0,0,12'h000,0,    64'h80000030,64'h80000034,1,64'h80000100,0,1, 12'h341,64'h80000034));
    vecs.push_back(mk(0,0,0,0,0,0,12'h000,0,            0,            0,            0,0,            0,1, 12'h300,64'h1880));
    vecs.push_back(mk(0,1,0,1,0,0,12'h000,0,    64'h80000020,64'h80000024,1,64'h80000100,0,1, 12'h341,64'h80000020));
    vecs.push_back(mk(0,1,0,1,0,1,12'h341,64'h1234,64'h80000040,64'h80000044,0,0,         0,1, 12'h341,64'h80000020));
    vecs.push_back(mk(0,0,0,0,0,0,12'h000,0,            0,            0,            0,0,            0,1, 12'h342,64'd11));
    vecs.push_back(mk(0,0,0,0,0,0,12'h000,0,            0,            0,            0,0,            0,1, 12'h300,64'h1800));
    vecs.push_back(mk(0,1,0,1,0,1,12'h300,64'h8, 64'h80000050,64'h80000054,1,64'h80000100,0,1, 12'h300,64'h1880));
    vecs.push_back(mk(0,0,0,0,0,0,12'h000,0,            0,            0,            0,0,            0,1, 12'h341,64'h80000050));
    vecs.push_back(mk(0,1,0,0,1,0,12'h000,0,    64'h80000060,64'h80000064,1,64'h80000050,1,1, 12'h300,64'h1888));
    vecs.push_back(mk(1,0,0,0,0,0,12'h000,0,            0,            0,            0,0,            0,0, 12'h300,64'h1800));
    vecs.push_back(mk(0,0,0,0,0,0,12'h000,0,            0,            0,            0,0,            0,0, 12'h305,64'h1000));

    foreach (vecs[i]) run_vector(vecs[i], $sformatf("vec%0d", i));

    // Sustained tint after a trap must not re-trap until mret re-enables MIE.
    run_vector(mk(0,1,0,0,0,1,12'h304,64'h80,0,0,0,0,0,1,12'h304,64'h80), "seq_mtie");
    run_vector(mk(0,1,0,0,0,1,12'h300,64'h8,0,0,0,0,1,1,12'h300,64'h1808), "seq_mie");
    run_vector(mk(0,1,1,0,0,0,0,0,64'h100,64'h104,1,64'h1000,0,1,12'h341,64'h104), "seq_trap");
    for (int i = 0; i < 10; i++)
      run_vector(mk(0,1,1,0,0,0,0,0,64'h104 + 64'(4*i),64'h108 + 64'(4*i),0,0,0,1,12'h342,
                    64'h8000000000000007), $sformatf("seq_hold%0d", i));
    run_vector(mk(0,1,1,0,1,0,0,0,64'h130,64'h134,1,64'h104,1,1,12'h300,64'h1888), "seq_mret");
    run_vector(mk(0,0,1,0,0,0,0,0,0,0,0,0,1,1,12'h344,64'h80), "seq_gap");
    run_vector(mk(0,1,1,0,0,0,0,0,64'h200,64'h204,1,64'h1000,0,1,12'h341,64'h204), "seq_retrap");

    // Randomized traffic; the first cycle resets DUT and model together.
    for (int c = 0; c < 3000; c++) begin
      apply_stimulus((c == 0) || ($urandom_range(63) == 0), $urandom_range(3) != 0,
                     $urandom_range(1) == 1, $urandom_range(7) == 0, $urandom_range(7) == 0,
                     $urandom_range(3) == 0, ADDRS[$urandom_range(7)],
                     {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      if ($urandom_range(1) == 1) csr_wdata[7:0] = 8'(($urandom_range(1) ? 8'h88 : 8'h80));
      #1;
      if (c != 0) check_output("rand csr_rdata", csr_rdata, model_read(csr_addr, tint));
      @(posedge clk);
      model_step();
      #1;
      check_output("rand redirect_valid", 64'(redirect_valid), 64'(m_rv));
      if (m_rv) check_output("rand redirect_pc", redirect_pc, m_rpc);
      check_output("rand MIE", 64'(mie_pin), 64'(m_mie));
      check_output("rand MTIE", 64'(mtie_pin), 64'(m_mtie));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
